sc_datamem_io_gen: RTL and testbench

- Parametrised single-clock data memory with a memory-mapped I/O block, for the single-cycle and pipelined CPU datapaths.
- Replaces the two-phase memory clocking scheme with a synchronous request interface and a 1-cycle read latency.
- Adds byte-lane writes and parametrised port counts and widths.
- Adds synchronised inputs, sticky input-change status with an interrupt mask, and a free-running cycle counter.
- Address bit IO_SEL_BIT selects the space: 0 selects data RAM, 1 selects I/O.

---
 rtl/sc_datamem_io_gen.sv | 155 +++++++++++++++
 tb/tb_sc_datamem_io_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_datamem_io_gen.sv
// Single-clock data RAM plus memory-mapped I/O block (outputs, synchronised inputs,
// sticky change status with mask/irq, free-running cycle counter); 1-cycle read latency.
module sc_datamem_io_gen #(
  parameter int MEM_AW     = 5,
  parameter int IO_SEL_BIT = 7,
  parameter int NUM_IN     = 3,
  parameter int IN_W       = 4,
  parameter int NUM_OUT    = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     rvalid,
  input  logic [NUM_IN*IN_W-1:0]   in_ports,
  output logic [NUM_OUT*32-1:0]    out_ports,
  output logic                     irq
);

  localparam int DEPTH = 1 << MEM_AW;

  logic [31:0] mem [DEPTH];

  logic [NUM_IN*IN_W-1:0] sync1_q, sync1_d;
  logic [NUM_IN*IN_W-1:0] sync2_q, sync2_d;
  logic [NUM_IN*IN_W-1:0] prev_q, prev_d;
  logic [NUM_IN-1:0]      status_q, status_d;
  logic [NUM_IN-1:0]      mask_q, mask_d;
  logic [NUM_IN-1:0]      chg;
  logic [31:0]            out_q [NUM_OUT];
  logic [31:0]            out_d [NUM_OUT];
  logic [31:0]            cnt_q, cnt_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   irq_q, irq_d;
  logic [31:0]            io_rdata;

  logic [MEM_AW-1:0] ram_idx;
  logic [4:0]        io_off;
  logic              is_io, wr, rd, io_wr;
  logic              unused_addr;

  assign ram_idx     = addr[MEM_AW+1:2];
  assign io_off      = addr[6:2];
  assign is_io       = addr[IO_SEL_BIT];
  assign wr          = req & we;
  assign rd          = req & ~we;
  assign io_wr       = wr & is_io;
  assign unused_addr = ^addr;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  lanes);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (lanes[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // RAM is deliberately outside the reset domain.
  always_ff @(posedge clock) begin
    if (wr && !is_io) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    sync1_d = in_ports;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    chg     = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      chg[k] = (sync2_q[k*IN_W +: IN_W] != prev_q[k*IN_W +: IN_W]);
    end

    // Change detection is OR-ed in after the W1C clear so a coincident set survives.
    status_d = status_q;
    if (io_wr && io_off == 5'd16 && be[0]) status_d = status_q & ~wdata[NUM_IN-1:0];
    status_d = status_d | chg;

    mask_d = mask_q;
    if (io_wr && io_off == 5'd17 && be[0]) mask_d = wdata[NUM_IN-1:0];

    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      out_d[k] = out_q[k];
      if (io_wr && io_off == 5'(k)) out_d[k] = lane_merge(out_q[k], wdata, be);
    end

    cnt_d = cnt_q + 32'd1;
    if (io_wr && io_off == 5'd18) cnt_d = lane_merge(cnt_q, wdata, be);

    irq_d = |(status_q & mask_q);
  end

  always_comb begin
    io_rdata = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (io_off == 5'(k)) io_rdata = out_q[k];
    end
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (io_off == 5'(8 + k)) io_rdata[IN_W-1:0] = sync2_q[k*IN_W +: IN_W];
    end
    if (io_off == 5'd16) io_rdata[NUM_IN-1:0] = status_q;
    if (io_off == 5'd17) io_rdata[NUM_IN-1:0] = mask_q;
    if (io_off == 5'd18) io_rdata = cnt_q;

    rdata_d  = rdata_q;
    rvalid_d = rd;
    if (rd) rdata_d = is_io ? io_rdata : mem[ram_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      status_q <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
      for (int unsigned k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      status_q <= status_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
      for (int unsigned k = 0; k < NUM_OUT; k++) out_q[k] <= out_d[k];
    end
  end

  always_comb begin
    out_ports = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) out_ports[k*32 +: 32] = out_q[k];
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_sc_datamem_io_gen.sv
// Directed + randomized bench for sc_datamem_io_gen against a behavioural memory/IO model.
module tb_sc_datamem_io_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        rvalid, irq;
  logic [11:0] in_ports = '0;
  logic [95:0] out_ports;

  int checks = 0;
  int errors = 0;

  sc_datamem_io_gen #(
    .MEM_AW(5), .IO_SEL_BIT(7), .NUM_IN(3), .IN_W(4), .NUM_OUT(3)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .in_ports(in_ports),
    .out_ports(out_ports), .irq(irq)
  );

  always #5 clock = ~clock;

  // Model state (values as seen just after each rising edge)
  logic [31:0] mem_m [32];
  logic [31:0] out_m [3];
  logic [2:0]  status_m, mask_m;
  logic [11:0] hist [3];    // input samples at the last three edges, newest first
  logic [31:0] load_val;
  int          edge_cnt = 0, load_edge = 0;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_irq;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] m;
    m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a, input logic [31:0] c);
    int off;
    if (!a[7]) return mem_m[a[6:2]];
    off = int'(a[6:2]);
    if (off < 3) return out_m[off];
    if (off >= 8 && off < 11) return {28'h0, hist[1][(off-8)*4 +: 4]};
    if (off == 16) return {29'h0, status_m};
    if (off == 17) return {29'h0, mask_m};
    if (off == 18) return c;
    return 32'h0;
  endfunction

  task automatic model_step();
    logic [31:0] cur;
    logic [2:0]  setb, clr;
    logic [11:0] h0, h1;
    cur = load_val + 32'(edge_cnt - load_edge);
    edge_cnt++;
    if (reset) begin
      m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0;
      for (int k = 0; k < 3; k++) out_m[k] = '0;
      status_m = '0; mask_m = '0;
      load_val = '0; load_edge = edge_cnt;
      for (int k = 0; k < 3; k++) hist[k] = '0;
      return;
    end
    m_irq    = |(status_m & mask_m);
    m_rvalid = req && !we;
    if (m_rvalid) m_rdata = mread(addr, cur);
    for (int k = 0; k < 3; k++) setb[k] = (hist[1][k*4 +: 4] != hist[2][k*4 +: 4]);
    clr = '0;
    if (req && we) begin
      if (!addr[7]) mem_m[addr[6:2]] = merge(mem_m[addr[6:2]], wdata, be);
      else begin
        case (int'(addr[6:2]))
          0, 1, 2: out_m[addr[6:2]] = merge(out_m[addr[6:2]], wdata, be);
          16: if (be[0]) clr = wdata[2:0];
          17: if (be[0]) mask_m = wdata[2:0];
          18: begin load_val = merge(cur, wdata, be); load_edge = edge_cnt; end
          default: ;
        endcase
      end
    end
    status_m = (status_m & ~clr) | setb;
    h0 = hist[0]; h1 = hist[1];
    hist[0] = in_ports; hist[1] = h0; hist[2] = h1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("rvalid", {31'h0, rvalid}, {31'h0, m_rvalid});
    check("rdata", rdata, m_rdata);
    check("irq", {31'h0, irq}, {31'h0, m_irq});
    for (int k = 0; k < 3; k++) check("out_port", out_ports[k*32 +: 32], out_m[k]);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; we = w; be = b; addr = a; wdata = d;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  logic [31:0] first_cnt, ra;
  logic [4:0]  offs [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11,
                             5'd16, 5'd17, 5'd18, 5'd25};

  initial begin
    for (int k = 0; k < 3; k++) hist[k] = '0;
    // Reset
    reset = 1'b1;
    idle(); idle();
    check("rst_rdata", rdata, 32'h0);
    check("rst_out", out_ports[31:0] | out_ports[63:32] | out_ports[95:64], 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++)
      drive(1'b1, 1'b1, 4'hF, 32'(i) << 2, 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101));

    // RAM survives reset; rvalid exactly one cycle after req
    drive(1'b1, 1'b1, 4'hF, 32'h0000_000C, 32'hCAFE_0003);
    reset = 1'b1; idle(); reset = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 32'h0000_000C, 32'h0);
    check("ram_after_reset", rdata, 32'hCAFE_0003);
    check("rvalid_pulse", {31'h0, rvalid}, 32'h1);
    idle();
    check("rvalid_drop", {31'h0, rvalid}, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 32'h0000_00C8, 32'h0);
    first_cnt = rdata;
    drive(1'b1, 1'b0, 4'h0, 32'h0000_00C8, 32'h0);
    check("cnt_incr", rdata - first_cnt, 32'h1);

    // Byte-lane merge, with aliasing upper address bits
    drive(1'b1, 1'b1, 4'hF, 32'h0000_0014, 32'hAABB_CCDD);
    drive(1'b1, 1'b1, 4'h5, 32'hFF00_0114, 32'h1122_3344);
    drive(1'b1, 1'b1, 4'h0, 32'h0000_0014, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 4'h0, 32'h0000_0014, 32'h0);
    check("word5_merge", rdata, 32'hAA22_CC44);

    // Output register and read-only input readback
    drive(1'b1, 1'b1, 4'hF, 32'h0000_0084, 32'h1234_5678);
    drive(1'b1, 1'b0, 4'h0, 32'h0000_0084, 32'h0);
    check("out1_read", rdata, 32'h1234_5678);
    check("out1_port", out_ports[63:32], 32'h1234_5678);
    drive(1'b1, 1'b1, 4'hF, 32'h0000_00A0, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 4'h0, 32'h0000_00A0, 32'h0);
    check("in_ro", rdata, 32'h0);

    // Input change -> sync, status, irq, W1C
    drive(1'b1, 1'b1, 4'h1, 32'h0000_00C4, 32'h1);
    in_ports = 12'h009;
    drive(1'b1, 1'b0, 4'h0, 32'h0000_00A0, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 32'h0000_00A0, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 32'h0000_00A0, 32'h0);
    check("in_sync2", rdata, 32'h9);
    drive(1'b1, 1'b0, 4'h0, 32'h0000_00C0, 32'h0);
    check("status_set", rdata, 32'h1);
    check("irq_set", {31'h0, irq}, 32'h1);
    drive(1'b1, 1'b1, 4'h1, 32'h0000_00C0, 32'h1);
    idle();
    check("irq_clear", {31'h0, irq}, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 32'h0000_00C0, 32'h0);
    check("status_clear", rdata, 32'h0);

    // Set beats a coincident W1C clear
    in_ports = 12'h005;
    idle(); idle();
    drive(1'b1, 1'b1, 4'h1, 32'h0000_00C0, 32'h1);
    drive(1'b1, 1'b0, 4'h0, 32'h0000_00C0, 32'h0);
    check("set_over_clear", rdata, 32'h1);
    drive(1'b1, 1'b1, 4'h1, 32'h0000_00C0, 32'h7);

    // Counter load and wrap
    drive(1'b1, 1'b1, 4'hF, 32'h0000_00C8, 32'hFFFF_FFFE);
    idle(); idle(); idle();
    drive(1'b1, 1'b0, 4'h0, 32'h0000_00C8, 32'h0);
    check("cnt_wrap", rdata, 32'h0000_0001);

    // Read issued during reset yields no rvalid
    reset = 1'b1;
    drive(1'b1, 1'b0, 4'h0, 32'h0000_0014, 32'h0);
    check("rst_read", {31'h0, rvalid}, 32'h0);
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      if ($urandom_range(1) == 0) ra[7] = 1'b0;
      else begin
        ra[7] = 1'b1;
        ra[6:2] = offs[$urandom_range(11)];
      end
      if ($urandom_range(3) == 0) in_ports = 12'($urandom);
      drive(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 4'($urandom), ra, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
